// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//
// Streams a program into the CPU instruction memory write port. A load is
// started with a one-cycle `start` pulse. The first accepted byte is a length
// byte L, and the load then writes N = L+1 words. Each word is assembled from
// INSTR_WIDTH/8 little-endian bytes and written at consecutive addresses
// starting at 0. The CPU is held in stall for the whole load.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the last word. It must equal the XOR
//   of all data bytes. On a mismatch the loader raises a sticky `err`, keeps
//   the CPU held and returns to idle without a `done` pulse.
//   When undefined, `err` is tied to 0.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   start          load request pulse (ignored while busy)
//   in_data        stream byte
//   in_valid       in_data valid
//   in_ready       loader accepts a byte this cycle
//   we             instruction memory write enable (one cycle per word)
//   wa             write address (wraps modulo MEM_DEPTH)
//   wd             write data (first stream byte of a word is the LSB)
//   cpu_hold       CPU stall request
//   busy           load in progress
//   done           one-cycle completion pulse
//   err            sticky checksum error
//   words_written  words written in the current or last load
// ---------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int MEM_DEPTH   = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   we,
    output logic [ADDR_WIDTH-1:0]  wa,
    output logic [INSTR_WIDTH-1:0] wd,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ADDR_WIDTH:0]    words_written
);

    localparam int BPW   = INSTR_WIDTH / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(BPW - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [7:0]       len_q;
    logic [IDX_W-1:0] idx_q;

    logic accept;
    logic last_byte;
    logic last_word;
    logic chk_fail;
    logic in_ready_next;
    logic busy_next;
    logic hold_next;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_sum;
`endif

    // A byte only moves when the registered in_ready is high, so in_ready
    // alone encodes which states consume bytes.
    assign accept    = in_valid && in_ready;
    assign last_byte = (idx_q == LAST_IDX);
    // words_written still holds the pre-increment count during WRITE, so the
    // final word (number L+1) is the one written when the count equals L.
    assign last_word = (words_written == (ADDR_WIDTH + 1)'(len_q));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The registered outputs are derived from next_state,
    // so each output is already correct in the first cycle of a new state.
    always_comb begin
        next_state = state;
        chk_fail   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (accept && last_byte) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    next_state = CHK;
`else
                    next_state = DONE;
`endif
                end else begin
                    next_state = DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    if (in_data == chk_sum) begin
                        next_state = DONE;
                    end else begin
                        chk_fail   = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
`endif
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        in_ready_next = (next_state == LEN) || (next_state == DATA);
`ifdef LOADER_CHECKSUM_EN
        if (next_state == CHK) begin
            in_ready_next = 1'b1;
        end
`endif
        busy_next = (next_state != IDLE) && (next_state != DONE);
        // The hold survives in IDLE only after a checksum failure. Normal
        // completion reaches IDLE through DONE, which has already cleared it.
        hold_next = busy_next || chk_fail || ((state == IDLE) && cpu_hold);
    end

    // Registered outputs and datapath: byte assembly, address and word
    // counters, and the running checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready      <= 1'b0;
            we            <= 1'b0;
            wa            <= '0;
            wd            <= '0;
            cpu_hold      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
            len_q         <= '0;
            idx_q         <= '0;
`ifdef LOADER_CHECKSUM_EN
            err           <= 1'b0;
            chk_sum       <= '0;
`endif
        end else begin
            in_ready <= in_ready_next;
            we       <= (next_state == WRITE);
            done     <= (next_state == DONE);
            busy     <= busy_next;
            cpu_hold <= hold_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        wa            <= '0;
                        words_written <= '0;
                        idx_q         <= '0;
`ifdef LOADER_CHECKSUM_EN
                        err           <= 1'b0;
                        chk_sum       <= '0;
`endif
                    end
                end
                LEN: begin
                    if (accept) begin
                        len_q <= in_data;
                    end
                end
                DATA: begin
                    if (accept) begin
                        wd[8*idx_q +: 8] <= in_data;
                        idx_q <= last_byte ? '0 : idx_q + IDX_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        chk_sum <= chk_sum ^ in_data;
`endif
                    end
                end
                WRITE: begin
                    wa            <= (wa == LAST_ADDR) ? '0 : wa + ADDR_WIDTH'(1);
                    words_written <= words_written + (ADDR_WIDTH + 1)'(1);
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (chk_fail) begin
                        err <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifndef LOADER_CHECKSUM_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
//
// Self-checking bench for instr_mem_loader. Each scenario task drives a load
// and compares the observed writes, handshake and status against a simple
// reference: word i is the little-endian packing of data bytes
// [BPW*i .. BPW*i+BPW-1], it is written at address i mod MEM_DEPTH, and with
// no stalls `done` appears 2 + N*(BPW+1) cycles after `start` (plus one
// cycle when LOADER_CHECKSUM_EN adds the checksum byte).
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int AW    = 8;
    localparam int IW    = 32;
    localparam int DEPTH = 256;
    localparam int BPW   = IW / 8;
`ifdef LOADER_CHECKSUM_EN
    localparam int CHK_CYC = 1;
`else
    localparam int CHK_CYC = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          we;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] wa;
    logic [IW-1:0] wd;
    logic [AW:0]   words_written;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic [7:0] data_b[$];
    logic [7:0] stream_q[$];
    logic [7:0] sent_q[$];

    logic [AW-1:0] wr_addr[$];
    logic [IW-1:0] wr_data[$];
    int            wr_cyc[$];
    logic          wr_rdy[$];
    logic [7:0]    acc_q[$];

    instr_mem_loader #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .we           (we),
        .wa           (wa),
        .wd           (wd),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_written(words_written)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle observer recording writes, consumed bytes and done pulses.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_addr.push_back(wa);
            wr_data.push_back(wd);
            wr_cyc.push_back(cyc);
            wr_rdy.push_back(in_ready);
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) begin
            acc_q.push_back(in_data);
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
        end
    end

    // Safety net against a hung DUT.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: expected word i from the data byte list.
    function automatic logic [IW-1:0] exp_word(input int i);
        logic [IW-1:0] w;
        w = '0;
        for (int k = 0; k < BPW; k++) begin
            w = w | (IW'(data_b[i*BPW + k]) << (8 * k));
        end
        return w;
    endfunction

    function automatic logic [7:0] exp_chk();
        logic [7:0] c;
        c = 8'h00;
        foreach (data_b[i]) c = c ^ data_b[i];
        return c;
    endfunction

    task automatic rand_data(input int n);
        data_b.delete();
        repeat (n * BPW) data_b.push_back(8'($urandom));
    endtask

    // Builds the byte stream: length byte, data bytes, optional checksum.
    task automatic build_stream();
        stream_q.delete();
        stream_q.push_back(8'(data_b.size() / BPW - 1));
        foreach (data_b[i]) stream_q.push_back(data_b[i]);
`ifdef LOADER_CHECKSUM_EN
        stream_q.push_back(exp_chk());
`endif
        sent_q = stream_q;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic start_load(output int t0);
        start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offers stream_q bytes, holding each one until it is accepted.
    // gap_pct is the chance of idling in_valid; start pulses at iteration start_at.
    task automatic send_stream(input int gap_pct, input int start_at);
        int   n;
        logic rdy;
        n = 0;
        while (stream_q.size() > 0 && n < 5000) begin
            in_valid = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? stream_q[0] : 8'($urandom);
            start    = (n == start_at);
            rdy      = in_ready;
            @(posedge clk);
            #1;
            if (in_valid && rdy) void'(stream_q.pop_front());
            n++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        checks++;
        if (stream_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL stream_timeout: got %0d bytes left, expected 0", stream_q.size());
        end
    endtask

    task automatic wait_idle(output int t1, output bit to);
        int k;
        k = 0;
        while (busy === 1'b1 && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        t1 = cyc;
        to = (busy !== 1'b0);
    endtask

    task automatic test_reset();
        int ab;
        do_reset();
        checks++;
        if ({in_ready, we, cpu_hold, busy, done, err} !== 6'b0 || wa !== '0 || wd !== '0 || words_written !== '0) begin
            failures++;
            $display("[TB] FAIL reset_values: got rdy=%b we=%b hold=%b busy=%b done=%b err=%b wa=%0h wd=%0h ww=%0d, expected all 0",
                     in_ready, we, cpu_hold, busy, done, err, wa, wd, words_written);
        end
        ab = acc_q.size();
        in_valid = 1'b1; in_data = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || acc_q.size() != ab) begin
            failures++;
            $display("[TB] FAIL idle_no_accept: got rdy=%b busy=%b consumed=%0d, expected 0 0 0", in_ready, busy, acc_q.size() - ab);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_single_word();
        int t0, t1, wb;
        bit to;
        data_b.delete();
        data_b.push_back(8'h13); data_b.push_back(8'h00); data_b.push_back(8'h00); data_b.push_back(8'h00);
        build_stream();
        wb = wr_addr.size();
        start_load(t0);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_len_entry: got rdy=%b busy=%b hold=%b, expected 1 1 1", in_ready, busy, cpu_hold);
        end
        send_stream(0, -1);
        wait_idle(t1, to);
        checks++;
        if (to || t1 != t0 + 2 + (BPW + 1) + CHK_CYC) begin
            failures++;
            $display("[TB] FAIL single_done_time: got %0d cycles, expected %0d", t1 - t0, 2 + (BPW + 1) + CHK_CYC);
        end
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || words_written !== (AW+1)'(1) || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_status: got done=%b hold=%b ww=%0d err=%b, expected 1 0 1 0", done, cpu_hold, words_written, err);
        end
        checks++;
        if (wr_addr.size() - wb != 1 || wr_addr[wb] !== '0 || wr_data[wb] !== 32'h0000_0013) begin
            failures++;
            $display("[TB] FAIL single_write: got count=%0d wa=%0h wd=%0h, expected 1 0 13", wr_addr.size() - wb, wr_addr[wb], wr_data[wb]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_done_pulse: got done=%b hold=%b busy=%b after pulse, expected 0 0 0", done, cpu_hold, busy);
        end
    endtask

    task automatic test_gapped_words();
        int t0, t1, wb, ab, n, bad;
        bit to;
        n = 3;
        rand_data(n);
        build_stream();
        wb = wr_addr.size();
        ab = acc_q.size();
        start_load(t0);
        send_stream(40, -1);
        wait_idle(t1, to);
        checks++;
        if (to || done !== 1'b1 || words_written !== (AW+1)'(n)) begin
            failures++;
            $display("[TB] FAIL gapped_status: got timeout=%b done=%b ww=%0d, expected 0 1 %0d", to, done, words_written, n);
        end
        checks++;
        if (wr_addr.size() - wb != n) begin
            failures++;
            $display("[TB] FAIL gapped_write_count: got %0d, expected %0d", wr_addr.size() - wb, n);
        end
        for (int i = 0; i < n && wb + i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[wb+i] !== AW'(i % DEPTH) || wr_data[wb+i] !== exp_word(i) || wr_rdy[wb+i] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL gapped_write[%0d]: got wa=%0h wd=%0h rdy=%b, expected wa=%0h wd=%0h rdy=0",
                         i, wr_addr[wb+i], wr_data[wb+i], wr_rdy[wb+i], i % DEPTH, exp_word(i));
            end
        end
        bad = (acc_q.size() - ab != sent_q.size()) ? 1 : 0;
        for (int i = 0; i < sent_q.size() && ab + i < acc_q.size(); i++) begin
            if (acc_q[ab+i] !== sent_q[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL gapped_byte_stream: got %0d bytes with %0d errors, expected %0d exact", acc_q.size() - ab, bad, sent_q.size());
        end
        bad = 0;
        for (int i = wb + 1; i < wr_cyc.size(); i++) begin
            if (wr_cyc[i] - wr_cyc[i-1] < 2) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL gapped_we_spacing: got %0d back-to-back we cycles, expected 0", bad);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_depth();
        int t0, t1, wb, n, bad;
        bit to;
        n = 256;
        rand_data(n);
        build_stream();
        wb = wr_addr.size();
        start_load(t0);
        send_stream(0, -1);
        wait_idle(t1, to);
        checks++;
        if (to || t1 != t0 + 2 + n * (BPW + 1) + CHK_CYC) begin
            failures++;
            $display("[TB] FAIL full_done_time: got %0d cycles, expected %0d", t1 - t0, 2 + n * (BPW + 1) + CHK_CYC);
        end
        checks++;
        if (done !== 1'b1 || words_written !== (AW+1)'(256) || wa !== '0) begin
            failures++;
            $display("[TB] FAIL full_status: got done=%b ww=%0d wa=%0h, expected 1 256 0", done, words_written, wa);
        end
        bad = (wr_addr.size() - wb != n) ? 1 : 0;
        for (int i = 0; i < n && wb + i < wr_addr.size(); i++) begin
            if (wr_addr[wb+i] !== AW'(i % DEPTH) || wr_data[wb+i] !== exp_word(i)) bad++;
        end
        checks++;
        if (bad != 0 || wr_addr[wr_addr.size()-1] !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL full_writes: got %0d bad writes, last wa=%0h, expected 0 bad, last wa=ff", bad, wr_addr[wr_addr.size()-1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_word();
        int t0, t1, wb, ab;
        bit to;
        rand_data(3);
        build_stream();
        while (stream_q.size() > 1 + BPW + 2) void'(stream_q.pop_back());
        wb = wr_addr.size();
        start_load(t0);
        send_stream(0, -1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, we, cpu_hold, busy, done, err} !== 6'b0 || wa !== '0 || wd !== '0 || words_written !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_values: got rdy=%b we=%b hold=%b busy=%b done=%b err=%b wa=%0h wd=%0h ww=%0d, expected all 0",
                     in_ready, we, cpu_hold, busy, done, err, wa, wd, words_written);
        end
        ab = acc_q.size();
        in_valid = 1'b1; in_data = 8'h5A;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (wr_addr.size() - wb != 1 || acc_q.size() != ab || wr_data[wb] !== exp_word(0)) begin
            failures++;
            $display("[TB] FAIL midreset_no_write: got writes=%0d consumed=%0d, expected 1 0", wr_addr.size() - wb, acc_q.size() - ab);
        end
        rand_data(2);
        build_stream();
        wb = wr_addr.size();
        start_load(t0);
        send_stream(20, -1);
        wait_idle(t1, to);
        checks++;
        if (to || done !== 1'b1 || wr_addr.size() - wb != 2 || wr_addr[wb] !== '0 || wr_data[wb] !== exp_word(0) ||
            wr_addr[wb+1] !== AW'(1) || wr_data[wb+1] !== exp_word(1)) begin
            failures++;
            $display("[TB] FAIL midreset_reload: got done=%b writes=%0d first wa=%0h wd=%0h, expected 1 2 0 %0h",
                     done, wr_addr.size() - wb, wr_addr[wb], wr_data[wb], exp_word(0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_ignored();
        int t0, t1, wb, db, bad;
        bit to;
        rand_data(2);
        build_stream();
        wb = wr_addr.size();
        db = done_cnt;
        start_load(t0);
        send_stream(0, 6);
        wait_idle(t1, to);
        checks++;
        if (to || t1 != t0 + 2 + 2 * (BPW + 1) + CHK_CYC || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_ignored_time: got %0d cycles done=%b, expected %0d 1", t1 - t0, done, 2 + 2 * (BPW + 1) + CHK_CYC);
        end
        @(posedge clk);
        #1;
        bad = (wr_addr.size() - wb != 2) ? 1 : 0;
        for (int i = 0; i < 2 && wb + i < wr_addr.size(); i++) begin
            if (wr_addr[wb+i] !== AW'(i) || wr_data[wb+i] !== exp_word(i)) bad++;
        end
        checks++;
        if (bad != 0 || done_cnt - db != 1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL start_ignored_result: got %0d bad writes, %0d done pulses, busy=%b, expected 0 1 0", bad, done_cnt - db, busy);
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1, wb, n, bad;
        bit to;
        repeat (4) begin
            n = $urandom_range(1, 5);
            rand_data(n);
            build_stream();
            wb = wr_addr.size();
            start_load(t0);
            send_stream(30, -1);
            wait_idle(t1, to);
            bad = (wr_addr.size() - wb != n) ? 1 : 0;
            for (int i = 0; i < n && wb + i < wr_addr.size(); i++) begin
                if (wr_addr[wb+i] !== AW'(i) || wr_data[wb+i] !== exp_word(i) || wr_rdy[wb+i] !== 1'b0) bad++;
            end
            checks++;
            if (to || bad != 0 || done !== 1'b1 || words_written !== (AW+1)'(n) || cpu_hold !== 1'b0) begin
                failures++;
                $display("[TB] FAIL back_to_back n=%0d: got %0d bad writes done=%b ww=%0d hold=%b, expected 0 1 %0d 0",
                         n, bad, done, words_written, cpu_hold, n);
            end
            @(posedge clk);
            #1;
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int t0, t1, db;
        bit to;
        data_b.delete();
        data_b.push_back(8'h44); data_b.push_back(8'h33); data_b.push_back(8'h22); data_b.push_back(8'h11);
        data_b.push_back(8'h01); data_b.push_back(8'h00); data_b.push_back(8'h00); data_b.push_back(8'h00);
        build_stream();
        start_load(t0);
        send_stream(0, -1);
        wait_idle(t1, to);
        checks++;
        if (to || done !== 1'b1 || err !== 1'b0 || t1 != t0 + 2 + 2 * (BPW + 1) + 1) begin
            failures++;
            $display("[TB] FAIL chk_good: got done=%b err=%b after %0d cycles, expected 1 0 %0d", done, err, t1 - t0, 2 + 2 * (BPW + 1) + 1);
        end
        @(posedge clk);
        #1;
        build_stream();
        stream_q[stream_q.size()-1] = 8'h00;
        db = done_cnt;
        start_load(t0);
        send_stream(0, -1);
        wait_idle(t1, to);
        checks++;
        if (to || done !== 1'b0 || err !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL chk_bad: got done=%b err=%b hold=%b busy=%b, expected 0 1 1 0", done, err, cpu_hold, busy);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != db || err !== 1'b1 || cpu_hold !== 1'b1) begin
            failures++;
            $display("[TB] FAIL chk_bad_sticky: got done pulses=%0d err=%b hold=%b, expected 0 1 1", done_cnt - db, err, cpu_hold);
        end
        start_load(t0);
        checks++;
        if (err !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL chk_restart: got err=%b hold=%b busy=%b, expected 0 1 1", err, cpu_hold, busy);
        end
        do_reset();
    endtask
`endif

    // Scenario sequence.
    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        test_reset();
        test_single_word();
        test_gapped_words();
        test_full_depth();
        test_reset_mid_word();
        test_start_ignored();
        test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
